jac_wb_regfile: RTL and testbench
=================================

Name: jac_wb_regfile

Overview:
- Write-back stage and register file directly downstream of ALU_J.
- Captures each ALU result/status into a 2-entry write-back queue and retires queued entries into an 8x8-bit register file and a 3-bit status register.
- A memory-load port has write priority over queue retirement.
- Two combinational read ports supply operand1/operand2 back to ALU_J.

Parameters:
- DataWidth, 8, register and result width
- NumStatusBits, 3, ALU status width: [0] overflow, [1] underflow, [2] zero
- NumRegs, 8, register count
- AddrBits, 3, register address width (log2 NumRegs)
- QDepth, 2, write-back queue entries (fixed at 2; other values are not supported)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  ALU result offered
- wb_ready  out  1  queue can accept
- wb_addr  in  AddrBits  destination register
- wb_result  in  DataWidth  ALU_J result
- wb_status  in  NumStatusBits  ALU_J status
- wb_flags_we  in  1  entry updates status register on retirement
- ld_we  in  1  memory-load write strobe, no handshake
- ld_addr  in  AddrBits  load destination
- ld_data  in  DataWidth  load data
- rd_addr1  in  AddrBits  operand1 read address
- rd_addr2  in  AddrBits  operand2 read address
- rd_data1  out  DataWidth  operand1 data, combinational
- rd_data2  out  DataWidth  operand2 data, combinational
- status_reg  out  NumStatusBits  architectural flags
- pending  out  2  queue occupancy (0..2)
- idle  out  1  pending==0

Behaviour:
- Reset (synchronous, rst=1 at a clk edge), applies mid-operation too:
  - all registers 0, status_reg 0, pending 0, queue contents discarded
  - wb_ready=1 and idle=1 from the first cycle after the reset edge
  - a wb_valid or ld_we present during the reset cycle is ignored
- Accept: push when wb_valid && wb_ready.
  - wb_ready = (pending < 2), derived from registered occupancy only.
  - A pop in the same cycle does not make a full queue ready.
- Retire, one per cycle: when pending>0 and ld_we=0:
  - head entry writes regs[addr] <= result
  - if the entry's flags_we: status_reg <= status
  - head is popped
- Load: ld_we=1 writes regs[ld_addr] <= ld_data that edge; retirement is stalled for that cycle. Loads never touch status_reg.
- Ordering: the queue is FIFO. Load-vs-queued-entry ordering to the same address is the issuing sequencer's responsibility; RTL writes in port-arrival order.
- Simultaneous push and pop with pending=1: occupancy stays 1; the new entry becomes head next cycle.
- Minimum latency: an entry accepted at edge N is visible in regs/status_reg after edge N+1, provided ld_we is low at N+1.
- Reads are combinational from the register array.
  - A same-edge write is visible only after the edge.
  - Without the feature, queued entries are not visible to reads.
- pending/idle are registered; status_reg is a pure register output.

Optional Feature:
- Macro: JAC_WB_BYPASS_EN.
- Defined: each read port forwards the youngest queued entry whose addr matches, else the register array. A pending result is readable the cycle after acceptance.
- Undefined: no forwarding, and no comparator logic is generated.

Decomposition:
- Shared package jac_pkg:
  - DataWidth, NumStatusBits, AddrBits
  - status bit indices STAT_OVF=0, STAT_UNF=1, STAT_ZERO=2
  - wb entry struct {addr, result, status, flags_we}
  - ALU opcode constants (common with ALU_J)
- One sub-module: jac_wb_queue (2-entry FIFO with valid/ready push, pop strobe, head and both-entry visibility for bypass). The register array and retire/priority logic stay in the top.

Test Plan:
- Reset, then read all 8 addresses -> every rd_data 0, status_reg 0, wb_ready=1, idle=1.
- Push {addr 3, result 8'h04, status 3'b000, flags_we 1}, ld_we low -> after 2 edges regs[3]=8'h04, status_reg=0, idle=1.
- Push {addr 5, 8'h00, 3'b100, flags_we 1}, then {addr 6, 8'h01, 3'b001, flags_we 0} back-to-back with ld_we held high:
  - pending=2, wb_ready=0, a third offer is not accepted
  - ld_we low -> regs[5]=0, status_reg=3'b100 after the first retire; regs[6]=1, status_reg still 3'b100 after the second
- ld_we with ld_addr 2, ld_data 8'hA5 concurrent with queued entry {addr 1, 8'hFF, 3'b010} -> regs[2]=8'hA5 that edge, regs[1]=8'hFF one edge later, status_reg=3'b010.
- Fill the queue, assert rst mid-operation -> pending=0, regs all 0, the queued writes never appear.
- With JAC_WB_BYPASS_EN: push {addr 4, 8'h30}, ld_we high, rd_addr1=4 -> rd_data1=8'h30 the cycle after acceptance. Without the macro -> rd_data1=0 until retirement.

Source files
------------

// File: rtl/jac_pkg.sv
// Shared ALU_J / write-back definitions: widths, status bit indices, queue entry type, opcodes.
package jac_pkg;

  localparam int unsigned DataWidth     = 8;
  localparam int unsigned NumStatusBits = 3;
  localparam int unsigned NumRegs       = 8;
  localparam int unsigned AddrBits      = 3;
  localparam int unsigned QDepth        = 2;

  localparam int unsigned STAT_OVF  = 0;
  localparam int unsigned STAT_UNF  = 1;
  localparam int unsigned STAT_ZERO = 2;

  // ALU_J opcodes, kept here so both stages agree on the encoding.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  typedef struct packed {
    logic [AddrBits-1:0]      addr;
    logic [DataWidth-1:0]     result;
    logic [NumStatusBits-1:0] status;
    logic                     flags_we;
  } wb_entry_t;

endpackage

// File: rtl/jac_wb_queue.sv
// Two-entry write-back FIFO; entry 0 is always the head. The tail view exists only when
// JAC_WB_BYPASS_EN is defined.
module jac_wb_queue
  import jac_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push_valid,
  output logic      push_ready,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic [1:0] count
`ifdef JAC_WB_BYPASS_EN
  ,
  output wb_entry_t tail
`endif
);

  wb_entry_t  e0_q, e0_d;
  wb_entry_t  e1_q, e1_d;
  logic [1:0] count_q, count_d;
  logic       push;

  // Readiness comes from registered occupancy only, so a same-cycle pop never frees a full queue.
  assign push_ready = (count_q != 2'd2);
  assign push       = push_valid && push_ready;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (pop && (count_q != 2'd0)) begin
      e0_d    = e1_q;
      count_d = count_q - 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) begin
        e0_d = push_entry;
      end else begin
        e1_d = push_entry;
      end
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head  = e0_q;
  assign count = count_q;
`ifdef JAC_WB_BYPASS_EN
  assign tail  = e1_q;
`endif

endmodule

// File: rtl/jac_wb_regfile.sv
// Write-back stage and 8x8 register file behind ALU_J. Define JAC_WB_BYPASS_EN to forward
// queued results to the read ports.
module jac_wb_regfile
  import jac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [AddrBits-1:0]      wb_addr,
  input  logic [DataWidth-1:0]     wb_result,
  input  logic [NumStatusBits-1:0] wb_status,
  input  logic                     wb_flags_we,
  input  logic                     ld_we,
  input  logic [AddrBits-1:0]      ld_addr,
  input  logic [DataWidth-1:0]     ld_data,
  input  logic [AddrBits-1:0]      rd_addr1,
  input  logic [AddrBits-1:0]      rd_addr2,
  output logic [DataWidth-1:0]     rd_data1,
  output logic [DataWidth-1:0]     rd_data2,
  output logic [NumStatusBits-1:0] status_reg,
  output logic [1:0]               pending,
  output logic                     idle
);

  logic [DataWidth-1:0]     regs_q [NumRegs];
  logic [DataWidth-1:0]     regs_d [NumRegs];
  logic [NumStatusBits-1:0] status_q, status_d;

  wb_entry_t  push_entry;
  wb_entry_t  head;
  logic [1:0] count;
  logic       pop;

  assign push_entry = '{addr: wb_addr, result: wb_result, status: wb_status,
                        flags_we: wb_flags_we};

  // Loads own the write port; retirement waits.
  assign pop = (count != 2'd0) && !ld_we;

`ifdef JAC_WB_BYPASS_EN
  wb_entry_t tail;

  jac_wb_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_valid (wb_valid),
    .push_ready (wb_ready),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .tail       (tail)
  );

  // Youngest matching entry wins: the tail when two are queued, else the head.
  function automatic logic [DataWidth-1:0] fwd_read(input logic [AddrBits-1:0] a);
    if ((count == 2'd2) && (tail.addr == a)) begin
      return tail.result;
    end else if ((count != 2'd0) && (head.addr == a)) begin
      return head.result;
    end
    return regs_q[a];
  endfunction

  assign rd_data1 = fwd_read(rd_addr1);
  assign rd_data2 = fwd_read(rd_addr2);
`else
  jac_wb_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_valid (wb_valid),
    .push_ready (wb_ready),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign rd_data1 = regs_q[rd_addr1];
  assign rd_data2 = regs_q[rd_addr2];
`endif

  always_comb begin
    regs_d   = regs_q;
    status_d = status_q;
    if (ld_we) begin
      regs_d[ld_addr] = ld_data;
    end else if (pop) begin
      regs_d[head.addr] = head.result;
      if (head.flags_we) begin
        status_d = head.status;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      status_q <= '0;
    end else begin
      regs_q   <= regs_d;
      status_q <= status_d;
    end
  end

  assign status_reg = status_q;
  assign pending    = count;
  assign idle       = (count == 2'd0);

endmodule

// File: tb/tb_jac_wb_regfile.sv
// Directed self-checking bench for jac_wb_regfile; expectations follow JAC_WB_BYPASS_EN.
module tb_jac_wb_regfile;
  import jac_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [AddrBits-1:0]      wb_addr;
  logic [DataWidth-1:0]     wb_result;
  logic [NumStatusBits-1:0] wb_status;
  logic                     wb_flags_we;
  logic                     ld_we;
  logic [AddrBits-1:0]      ld_addr;
  logic [DataWidth-1:0]     ld_data;
  logic [AddrBits-1:0]      rd_addr1;
  logic [AddrBits-1:0]      rd_addr2;
  logic [DataWidth-1:0]     rd_data1;
  logic [DataWidth-1:0]     rd_data2;
  logic [NumStatusBits-1:0] status_reg;
  logic [1:0]               pending;
  logic                     idle;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

`ifdef JAC_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  jac_wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_result   (wb_result),
    .wb_status   (wb_status),
    .wb_flags_we (wb_flags_we),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .status_reg  (status_reg),
    .pending     (pending),
    .idle        (idle)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd1(input string tag, input logic [AddrBits-1:0] a, input logic [7:0] exp);
    rd_addr1 = a;
    #1;
    check(tag, {24'd0, rd_data1}, {24'd0, exp});
  endtask

  task automatic rd2(input string tag, input logic [AddrBits-1:0] a, input logic [7:0] exp);
    rd_addr2 = a;
    #1;
    check(tag, {24'd0, rd_data2}, {24'd0, exp});
  endtask

  task automatic offer(input logic [2:0] a, input logic [7:0] r, input logic [2:0] s,
                       input logic f);
    wb_valid    = 1'b1;
    wb_addr     = a;
    wb_result   = r;
    wb_status   = s;
    wb_flags_we = f;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_result = '0; wb_status = '0;
    wb_flags_we = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      rd1("rst_rd1", 3'(i), 8'h00);
      rd2("rst_rd2", 3'(7 - i), 8'h00);
    end
    check("rst_status", {29'd0, status_reg}, 32'd0);
    check("rst_ready", {31'd0, wb_ready}, 32'd1);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_pending", {30'd0, pending}, 32'd0);

    // Single push, minimum latency
    offer(3'd3, 8'h04, 3'b000, 1'b1);
    tick();
    wb_valid = 1'b0;
    check("p1_pending", {30'd0, pending}, 32'd1);
    rd1("p1_early", 3'd3, Bypass ? 8'h04 : 8'h00);
    tick();
    rd1("p1_reg3", 3'd3, 8'h04);
    check("p1_status", {29'd0, status_reg}, 32'd0);
    check("p1_idle", {31'd0, idle}, 32'd1);

    // Fill queue under continuous load, then drain
    ld_we = 1'b1; ld_addr = 3'd7; ld_data = 8'h77;
    offer(3'd5, 8'h00, 3'b100, 1'b1);
    tick();
    offer(3'd6, 8'h01, 3'b001, 1'b0);
    tick();
    check("full_pending", {30'd0, pending}, 32'd2);
    check("full_ready", {31'd0, wb_ready}, 32'd0);
    check("full_idle", {31'd0, idle}, 32'd0);
    offer(3'd0, 8'hEE, 3'b111, 1'b1);
    tick();
    wb_valid = 1'b0;
    check("third_rejected", {30'd0, pending}, 32'd2);
    rd2("ld_reg7", 3'd7, 8'h77);
    rd1("stall_reg6", 3'd6, Bypass ? 8'h01 : 8'h00);
    ld_we = 1'b0;
    tick();
    rd1("ret1_reg5", 3'd5, 8'h00);
    check("ret1_status", {29'd0, status_reg}, 32'b100);
    check("ret1_pending", {30'd0, pending}, 32'd1);
    tick();
    rd1("ret2_reg6", 3'd6, 8'h01);
    check("ret2_status", {29'd0, status_reg}, 32'b100);
    check("ret2_idle", {31'd0, idle}, 32'd1);
    tick();
    rd1("third_never", 3'd0, 8'h00);

    // Load stalls a queued entry for one edge
    offer(3'd1, 8'hFF, 3'b010, 1'b1);
    tick();
    wb_valid = 1'b0;
    ld_we = 1'b1; ld_addr = 3'd2; ld_data = 8'hA5;
    tick();
    ld_we = 1'b0;
    rd1("ld_reg2", 3'd2, 8'hA5);
    rd2("ld_stall_reg1", 3'd1, Bypass ? 8'hFF : 8'h00);
    check("ld_stall_status", {29'd0, status_reg}, 32'b100);
    tick();
    rd1("ld_ret_reg1", 3'd1, 8'hFF);
    check("ld_ret_status", {29'd0, status_reg}, 32'b010);

    // Push and pop together at occupancy 1
    offer(3'd4, 8'h44, 3'b000, 1'b0);
    tick();
    offer(3'd5, 8'h55, 3'b000, 1'b0);
    tick();
    wb_valid = 1'b0;
    check("pp_pending", {30'd0, pending}, 32'd1);
    rd1("pp_reg4", 3'd4, 8'h44);
    tick();
    rd1("pp_reg5", 3'd5, 8'h55);
    check("pp_idle", {31'd0, idle}, 32'd1);

    // Reset mid-operation with a full queue and live strobes
    ld_we = 1'b1; ld_addr = 3'd6; ld_data = 8'h66;
    offer(3'd4, 8'h11, 3'b111, 1'b1);
    tick();
    offer(3'd5, 8'h22, 3'b111, 1'b1);
    tick();
    check("pre_rst_pending", {30'd0, pending}, 32'd2);
    rst = 1'b1;
    offer(3'd3, 8'h33, 3'b111, 1'b1);
    tick();
    rst = 1'b0; wb_valid = 1'b0; ld_we = 1'b0;
    check("mrst_pending", {30'd0, pending}, 32'd0);
    check("mrst_ready", {31'd0, wb_ready}, 32'd1);
    check("mrst_idle", {31'd0, idle}, 32'd1);
    check("mrst_status", {29'd0, status_reg}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd1("mrst_regs", 3'(i), 8'h00);
    end
    tick();
    tick();
    rd1("mrst_no_ret4", 3'd4, 8'h00);
    rd2("mrst_no_ret5", 3'd5, 8'h00);
    check("mrst_status_late", {29'd0, status_reg}, 32'd0);

    // Forwarding window while a load holds the write port
    ld_we = 1'b1; ld_addr = 3'd7; ld_data = 8'h5A;
    offer(3'd4, 8'h30, 3'b000, 1'b0);
    tick();
    wb_valid = 1'b0;
    rd1("byp_next", 3'd4, Bypass ? 8'h30 : 8'h00);
    tick();
    rd1("byp_hold", 3'd4, Bypass ? 8'h30 : 8'h00);
    rd2("byp_ld7", 3'd7, 8'h5A);
    ld_we = 1'b0;
    tick();
    rd1("byp_retired", 3'd4, 8'h30);
    check("byp_idle", {31'd0, idle}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
